// File: rtl/melody_sequencer_pkg.sv
// Shared music constants, sequencer state encoding and rest substitution.
// Latency: n/a (package).
// Backpressure: n/a.
package melody_sequencer_pkg;

  // One note slot per 1/8 s at a 100 MHz core clock
  localparam int unsigned BEAT_DIV_100MHZ = 12_500_000;

  // Rests and idle map to this frequency (divider 1 = inaudible)
  localparam logic [31:0] SILENCE_HZ = 32'd50_000_000;

  // Low octave
  localparam logic [31:0] LC = 32'd262;
  localparam logic [31:0] LD = 32'd294;
  localparam logic [31:0] LE = 32'd330;
  localparam logic [31:0] LF = 32'd349;
  localparam logic [31:0] LG = 32'd392;
  localparam logic [31:0] LA = 32'd440;
  localparam logic [31:0] LB = 32'd494;
  // Middle octave
  localparam logic [31:0] MC = 32'd523;
  localparam logic [31:0] MD = 32'd587;
  localparam logic [31:0] ME = 32'd659;
  localparam logic [31:0] MF = 32'd698;
  localparam logic [31:0] MG = 32'd784;
  localparam logic [31:0] MA = 32'd880;
  localparam logic [31:0] MB = 32'd988;
  // High octave
  localparam logic [31:0] HC = 32'd1047;
  localparam logic [31:0] HD = 32'd1175;
  localparam logic [31:0] HE = 32'd1319;
  localparam logic [31:0] HF = 32'd1397;
  localparam logic [31:0] HG = 32'd1568;
  localparam logic [31:0] HA = 32'd1760;
  localparam logic [31:0] HB = 32'd1976;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_PLAY  = 3'd3,
    ST_PAUSE = 3'd4
  } state_e;

  // A ROM value of 0 marks a rest; it is played as the silence frequency
  function automatic logic [31:0] rest_subst(input logic [31:0] rom_hz,
                                             input logic [31:0] silence_hz);
    return (rom_hz == 32'd0) ? silence_hz : rom_hz;
  endfunction

endpackage

// File: rtl/melody_sequencer_beat_timer.sv
// Note-slot timer: counts 0..BEAT_DIV-1 while enabled, flags last cycle and gap window.
// Latency: tc/gap are combinational from the registered count.
// Backpressure: none; en freezes the count, clr forces it to 0 (clr wins).
module melody_sequencer_beat_timer #(
  parameter int unsigned BEAT_DIV = 4,
  parameter int unsigned GAP_CYC  = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc,
  output logic gap
);

  localparam int unsigned CNT_W     = $clog2(BEAT_DIV);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(BEAT_DIV - 1);
  // Count never exceeds BEAT_DIV-1, so GAP_CYC=0 leaves the window empty
  localparam int unsigned GAP_START = BEAT_DIV - GAP_CYC;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc  = (cnt_q == TC_VAL);
  assign gap = (32'(cnt_q) >= GAP_START);

  // Next count: clear, hold, or advance with wrap at the slot end
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: steps an external sync note ROM one entry per beat, drives L/R tone Hz.
// Latency: start sampled at edge t -> first note on freq_*/mute after edge t+2; no bubble between notes.
// Backpressure: none; control pulses act immediately with priority stop > pause > start.
module melody_sequencer #(
  parameter int unsigned BEAT_DIV   = melody_sequencer_pkg::BEAT_DIV_100MHZ,
  parameter int unsigned SONG_LEN   = 64,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned GAP_CYC    = 0,
  parameter logic [31:0] SILENCE_HZ = melody_sequencer_pkg::SILENCE_HZ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_freq_l,
  input  logic [31:0]       rom_freq_r,
  output logic [31:0]       freq_l,
  output logic [31:0]       freq_r,
  output logic              mute,
  output logic              playing,
  output logic [ADDR_W-1:0] note_idx,
  output logic              done
);

  import melody_sequencer_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SONG_LEN - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] note_idx_q, note_idx_d;
  logic [31:0]       freq_l_q, freq_l_d;
  logic [31:0]       freq_r_q, freq_r_d;
  logic              done_q, done_d;

  logic              tmr_en, tmr_clr, tmr_tc, tmr_gap;
  logic              is_last, slot_end, song_end;
  logic [ADDR_W-1:0] next_idx;

  assign is_last  = (note_idx_q == LAST_IDX);
  assign next_idx = is_last ? '0 : note_idx_q + ADDR_W'(1);
  assign slot_end = (state_q == ST_PLAY) && tmr_tc;
  // loop_en only matters here, at the end of the final slot
  assign song_end = slot_end && is_last && !loop_en;

  melody_sequencer_beat_timer #(
    .BEAT_DIV (BEAT_DIV),
    .GAP_CYC  (GAP_CYC)
  ) u_beat_timer (
    .clk (clk),
    .rst (rst),
    .en  (tmr_en),
    .clr (tmr_clr),
    .tc  (tmr_tc),
    .gap (tmr_gap)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; stop overrides everything, song end beats a same-cycle pause
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_PLAY;
      ST_PLAY: begin
        if (song_end)   state_d = ST_IDLE;
        else if (pause) state_d = ST_PAUSE;
      end
      ST_PAUSE: if (pause || start) state_d = ST_PLAY;
      default:  state_d = ST_IDLE;
    endcase
    if (stop) state_d = ST_IDLE;
  end

  // State-decoded outputs: ROM prefetch address, mute, playing, timer enable
  always_comb begin
    rom_addr = '0;
    mute     = 1'b1;
    playing  = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      ST_PLAY: begin
        rom_addr = next_idx;
        mute     = tmr_gap;
        playing  = 1'b1;
        tmr_en   = 1'b1;
      end
      ST_PAUSE: rom_addr = next_idx;
      default: ;
    endcase
  end

  // Note datapath: load first note, advance at slot end, silence whenever headed to IDLE
  always_comb begin
    freq_l_d   = freq_l_q;
    freq_r_d   = freq_r_q;
    note_idx_d = note_idx_q;
    done_d     = 1'b0;
    tmr_clr    = 1'b0;
    if (state_q == ST_LOAD) begin
      freq_l_d   = rest_subst(rom_freq_l, SILENCE_HZ);
      freq_r_d   = rest_subst(rom_freq_r, SILENCE_HZ);
      note_idx_d = '0;
      tmr_clr    = 1'b1;
    end else if (slot_end && !song_end) begin
      freq_l_d   = rest_subst(rom_freq_l, SILENCE_HZ);
      freq_r_d   = rest_subst(rom_freq_r, SILENCE_HZ);
      note_idx_d = next_idx;
    end
    if (song_end && !stop) done_d = 1'b1;
    if (state_d == ST_IDLE) begin
      freq_l_d   = SILENCE_HZ;
      freq_r_d   = SILENCE_HZ;
      note_idx_d = '0;
      tmr_clr    = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq_l_q   <= SILENCE_HZ;
      freq_r_q   <= SILENCE_HZ;
      note_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      freq_l_q   <= freq_l_d;
      freq_r_q   <= freq_r_d;
      note_idx_q <= note_idx_d;
      done_q     <= done_d;
    end
  end

  assign freq_l   = freq_l_q;
  assign freq_r   = freq_r_q;
  assign note_idx = note_idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a 4-entry synchronous ROM model.
// Cycle numbers count rising edges after reset release; a pulse at cycle n is sampled on edge n,
// and the expected outputs at cycle n are those seen between edge n and edge n+1.
module tb_melody_sequencer;
  import melody_sequencer_pkg::*;

  localparam logic [31:0] S = SILENCE_HZ;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, pause = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [1:0]  rom_addr;
  logic [31:0] rom_freq_l = '0, rom_freq_r = '0;
  logic [31:0] freq_l, freq_r;
  logic        mute, playing, done;
  logic [1:0]  note_idx;

  logic [31:0] rom_l [4];
  logic [31:0] rom_r [4];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  melody_sequencer #(
    .BEAT_DIV (4),
    .SONG_LEN (4),
    .ADDR_W   (2),
    .GAP_CYC  (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .loop_en    (loop_en),
    .rom_addr   (rom_addr),
    .rom_freq_l (rom_freq_l),
    .rom_freq_r (rom_freq_r),
    .freq_l     (freq_l),
    .freq_r     (freq_r),
    .mute       (mute),
    .playing    (playing),
    .note_idx   (note_idx),
    .done       (done)
  );

  // Synchronous note ROM, one-cycle read latency
  always_ff @(posedge clk) begin
    rom_freq_l <= rom_l[rom_addr];
    rom_freq_r <= rom_r[rom_addr];
  end

  typedef struct {
    int start_a; int start_b; int pause_a; int pause_b; int stop_e;
    logic loop; int last; int exp_done;
  } scen_t;

  typedef struct {
    int scen; int cyc;
    logic [31:0] fl; logic [31:0] fr;
    logic mute; logic play; logic done;
    logic [1:0] idx; logic [1:0] addr;
  } chk_t;

  localparam int NSCEN = 4;
  localparam int NCHK  = 23;
  scen_t scen [NSCEN];
  chk_t  chks [NCHK];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] fl, input logic [31:0] fr,
                               input logic mu, input logic pl, input logic dn,
                               input logic [1:0] ix, input logic [1:0] ad);
    chk({tag, " freq_l"},   freq_l,          fl);
    chk({tag, " freq_r"},   freq_r,          fr);
    chk({tag, " mute"},     32'(mute),       32'(mu));
    chk({tag, " playing"},  32'(playing),    32'(pl));
    chk({tag, " done"},     32'(done),       32'(dn));
    chk({tag, " note_idx"}, 32'(note_idx),   32'(ix));
    chk({tag, " rom_addr"}, 32'(rom_addr),   32'(ad));
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; loop_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_outputs("reset", S, S, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    rst = 1'b0;
  endtask

  task automatic run_scen(input int si);
    int dn;
    dn = 0;
    do_reset();
    loop_en = scen[si].loop;
    for (int c = 1; c <= scen[si].last; c++) begin
      start = (c == scen[si].start_a) || (c == scen[si].start_b);
      pause = (c == scen[si].pause_a) || (c == scen[si].pause_b);
      stop  = (c == scen[si].stop_e);
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) dn++;
      for (int k = 0; k < NCHK; k++) begin
        if (chks[k].scen == si && chks[k].cyc == c)
          check_outputs($sformatf("s%0d c%0d", si, c), chks[k].fl, chks[k].fr,
                        chks[k].mute, chks[k].play, chks[k].done, chks[k].idx, chks[k].addr);
      end
    end
    start = 1'b0; pause = 1'b0; stop = 1'b0;
    chk($sformatf("s%0d done_count", si), dn, scen[si].exp_done);
  endtask

  initial begin
    rom_l[0] = LC; rom_l[1] = 32'd0; rom_l[2] = LG;    rom_l[3] = LA;
    rom_r[0] = LE; rom_r[1] = LB;    rom_r[2] = 32'd0; rom_r[3] = MC;

    //           start_a start_b pause_a pause_b stop  loop  last done
    scen[0] = '{10, 0,  5,  0,  0,  1'b0, 30, 1};  // plain play, pause in IDLE ignored
    scen[1] = '{10, 14, 0,  0,  0,  1'b1, 32, 0};  // loop, start in PLAY ignored
    scen[2] = '{10, 0,  14, 21, 0,  1'b0, 30, 0};  // pause / resume mid-note
    scen[3] = '{10, 20, 17, 0,  17, 1'b0, 24, 0};  // stop+pause together, then restart

    //          scen cyc  freq_l  freq_r  mute  play  done  idx   addr
    chks[0]  = '{0, 6,  S,      S,      1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
    chks[1]  = '{0, 11, S,      S,      1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
    chks[2]  = '{0, 12, 32'd262, 32'd330, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1};
    chks[3]  = '{0, 15, 32'd262, 32'd330, 1'b1, 1'b1, 1'b0, 2'd0, 2'd1};
    chks[4]  = '{0, 16, S,      32'd494, 1'b0, 1'b1, 1'b0, 2'd1, 2'd2};
    chks[5]  = '{0, 20, 32'd392, S,      1'b0, 1'b1, 1'b0, 2'd2, 2'd3};
    chks[6]  = '{0, 24, 32'd440, 32'd523, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0};
    chks[7]  = '{0, 27, 32'd440, 32'd523, 1'b1, 1'b1, 1'b0, 2'd3, 2'd0};
    chks[8]  = '{0, 28, S,      S,      1'b1, 1'b0, 1'b1, 2'd0, 2'd0};
    chks[9]  = '{0, 29, S,      S,      1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
    chks[10] = '{1, 16, S,      32'd494, 1'b0, 1'b1, 1'b0, 2'd1, 2'd2};
    chks[11] = '{1, 28, 32'd262, 32'd330, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1};
    chks[12] = '{1, 31, 32'd262, 32'd330, 1'b1, 1'b1, 1'b0, 2'd0, 2'd1};
    chks[13] = '{1, 32, S,      32'd494, 1'b0, 1'b1, 1'b0, 2'd1, 2'd2};
    chks[14] = '{2, 14, 32'd262, 32'd330, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1};
    chks[15] = '{2, 20, 32'd262, 32'd330, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1};
    chks[16] = '{2, 21, 32'd262, 32'd330, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1};
    chks[17] = '{2, 22, 32'd262, 32'd330, 1'b1, 1'b1, 1'b0, 2'd0, 2'd1};
    chks[18] = '{2, 23, S,      32'd494, 1'b0, 1'b1, 1'b0, 2'd1, 2'd2};
    chks[19] = '{3, 17, S,      S,      1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
    chks[20] = '{3, 18, S,      S,      1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
    chks[21] = '{3, 21, S,      S,      1'b1, 1'b0, 1'b0, 2'd0, 2'd0};
    chks[22] = '{3, 22, 32'd262, 32'd330, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1};

    for (int si = 0; si < NSCEN; si++) run_scen(si);

    // Asynchronous reset in the middle of the third note, then replay from index 0
    do_reset();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    check_outputs("pre-rst", 32'd392, S, 1'b0, 1'b1, 1'b0, 2'd2, 2'd3);
    rst = 1'b1;
    #1;
    check_outputs("async-rst", S, S, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_outputs("replay", 32'd262, 32'd330, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
